// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the MIPS register-file write port (we3/wa3/wd3)
// between the pipeline writeback stage and a long-latency result FIFO.
// It also keeps a busy scoreboard of pending long-latency destinations.
// When FIFO results are starved of the port, it raises a registered stall request.
// Optional feature macro: RF_WB_BYPASS_EN. When it is defined, a result that arrives
// while the FIFO is empty and the pipeline is idle is written in the same cycle.
module rf_wb_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pwb_we,
   input  logic [4:0]  pwb_wa,
   input  logic [31:0] pwb_wd,
   input  logic        lu_issue,
   input  logic [4:0]  lu_issue_wa,
   input  logic        lu_valid,
   input  logic [4:0]  lu_wa,
   input  logic [31:0] lu_wd,
   output logic        lu_ready,
   output logic        we3,
   output logic [4:0]  wa3,
   output logic [31:0] wd3,
   output logic [31:0] busy,
   output logic        stall_req,
   output logic        issue_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
   localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);

   logic [4:0]       fifoWa_q [FIFO_DEPTH];
   logic [31:0]      fifoWd_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      busy_q, busy_d;
   logic [3:0]       starveCnt_q, starveCnt_d;
   logic             stallReq_q, stallReq_d;
   logic             issueErr_q, issueErr_d;

   logic             fifoEmpty;
   logic             fifoFull;
   logic             pipeGrant;
   logic             popGrant;
   logic             bypassGrant;
   logic             pushEn;
   logic [4:0]       headWa;
   logic [31:0]      headWd;
   logic [31:0]      clrMask;
   logic [31:0]      setMask;

   assign headWa    = fifoWa_q[rdPtr_q];
   assign headWd    = fifoWd_q[rdPtr_q];
   assign fifoEmpty = (count_q == '0);
   assign fifoFull  = (count_q == FULL_CNT);

   assign busy      = busy_q;
   assign stall_req = stallReq_q;
   assign issue_err = issueErr_q;

   // Port grant: pipeline first, then FIFO head, then (optionally) bypass; everything gated off in reset
   always_comb begin
      lu_ready    = reset & ~fifoFull;
      pipeGrant   = reset & pwb_we & (pwb_wa != 5'd0);
      popGrant    = reset & ~pipeGrant & ~fifoEmpty;
      bypassGrant = 1'b0;
`ifdef RF_WB_BYPASS_EN
      bypassGrant = reset & ~pipeGrant & fifoEmpty & lu_valid & (lu_wa != 5'd0);
`endif
      we3 = 1'b0;
      wa3 = 5'd0;
      wd3 = 32'd0;
      if (pipeGrant) begin
         we3 = 1'b1;
         wa3 = pwb_wa;
         wd3 = pwb_wd;
      end else if (popGrant) begin
         we3 = 1'b1;
         wa3 = headWa;
         wd3 = headWd;
      end else if (bypassGrant) begin
         we3 = 1'b1;
         wa3 = lu_wa;
         wd3 = lu_wd;
      end
      pushEn = lu_valid & lu_ready & (lu_wa != 5'd0) & ~bypassGrant;
   end

   // Next-state for FIFO pointers/occupancy, scoreboard, error flag and starvation tracking
   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      clrMask     = 32'd0;
      setMask     = 32'd0;
      issueErr_d  = issueErr_q;
      starveCnt_d = starveCnt_q;

      if (pushEn) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popGrant) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (pushEn && !popGrant) begin
         count_d = count_q + CNT_W'(1);
      end else if (!pushEn && popGrant) begin
         count_d = count_q - CNT_W'(1);
      end

      if (popGrant) begin
         clrMask[headWa] = 1'b1;
      end
      if (bypassGrant) begin
         clrMask[lu_wa] = 1'b1;
      end
      if (lu_issue && (lu_issue_wa != 5'd0)) begin
         setMask[lu_issue_wa] = 1'b1;
         if (busy_q[lu_issue_wa]) begin
            issueErr_d = 1'b1;
         end
      end
      busy_d = ((busy_q & ~clrMask) | setMask) & ~32'd1;

      if (popGrant || fifoEmpty) begin
         starveCnt_d = 4'd0;
      end else if (starveCnt_q != STARVE_LIM) begin
         starveCnt_d = starveCnt_q + 4'd1;
      end
      stallReq_d = (starveCnt_d == STARVE_LIM);
   end

   // Control state register; reset drops all queued results and reservations
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         busy_q      <= 32'd0;
         starveCnt_q <= 4'd0;
         stallReq_q  <= 1'b0;
         issueErr_q  <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         starveCnt_q <= starveCnt_d;
         stallReq_q  <= stallReq_d;
         issueErr_q  <= issueErr_d;
      end
   end

   // FIFO storage needs no reset since occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (pushEn) begin
         fifoWa_q[wrPtr_q] <= lu_wa;
         fifoWd_q[wrPtr_q] <= lu_wd;
      end
   end

endmodule
